// File: rtl/demux1x2_buf.sv
// demux1x2_buf: buffered 1-to-2 demultiplexer.
// Each input word is steered by its tag s into one of two show-ahead FIFOs,
// and each FIFO drains through its own valid/ready output port.
// Optional build macro: DEMUX1X2_BUF_STATS_EN adds per-channel push counters
// (acc0/acc1, saturating at 16'hFFFF, cleared by reset or flush).
module demux1x2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [AW:0]      cnt0,
    output logic [AW:0]      cnt1
`ifdef DEMUX1X2_BUF_STATS_EN
    ,
    output logic [15:0]      acc0,
    output logic [15:0]      acc1
`endif
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Per-channel views so the channel logic can be generated once.
    logic [AW:0]      cnt_arr   [2];
    logic [WIDTH-1:0] y_arr     [2];
    logic             valid_arr [2];
    logic             ready_arr [2];

    assign ready_arr[0] = y0_ready;
    assign ready_arr[1] = y1_ready;
    assign y0       = y_arr[0];
    assign y1       = y_arr[1];
    assign y0_valid = valid_arr[0];
    assign y1_valid = valid_arr[1];
    assign cnt0     = cnt_arr[0];
    assign cnt1     = cnt_arr[1];

    // Acceptance looks only at the selected channel's occupancy; a pop in the
    // same cycle does not free space for the push (no ready-to-ready path).
    assign d_ready = clrn & ~flush & (cnt_arr[s] != CNT_FULL);

`ifdef DEMUX1X2_BUF_STATS_EN
    logic [15:0] acc_arr [2];
    assign acc0 = acc_arr[0];
    assign acc1 = acc_arr[1];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]    wr_ptr_reg;
            logic [AW-1:0]    rd_ptr_reg;
            logic [AW:0]      cnt_reg;
            logic             push;
            logic             pop;

            // d_ready already folds in reset, flush and full.
            assign push = d_valid & d_ready & (s == 1'(gi));
            // Flush discards a pop presented in the same cycle.
            assign pop  = (cnt_reg != '0) & ready_arr[gi] & ~flush;

            assign cnt_arr[gi]   = cnt_reg;
            assign valid_arr[gi] = (cnt_reg != '0);
            assign y_arr[gi]     = (cnt_reg != '0) ? mem[rd_ptr_reg] : '0;

            // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
            always_ff @(posedge clk) begin
                if (!clrn || flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    if (push && !pop)
                        cnt_reg <= cnt_reg + CNT_ONE;
                    else if (pop && !push)
                        cnt_reg <= cnt_reg - CNT_ONE;
                end
            end

            // Storage write; contents are intentionally left unreset.
            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr_reg] <= d;
            end

`ifdef DEMUX1X2_BUF_STATS_EN
            logic [15:0] acc_reg;
            assign acc_arr[gi] = acc_reg;

            // Saturating count of words accepted into this channel.
            always_ff @(posedge clk) begin
                if (!clrn || flush)
                    acc_reg <= '0;
                else if (push && acc_reg != 16'hFFFF)
                    acc_reg <= acc_reg + 16'd1;
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_demux1x2_buf.sv
// Self-checking bench for demux1x2_buf (WIDTH=32, DEPTH=4).
// Directed per-cycle vector table plus a wrap/stream sequence and,
// when DEMUX1X2_BUF_STATS_EN is defined, push-counter checks.
module tb_demux1x2_buf;

    logic        clk = 1'b0;
    logic        clrn, flush, s, d_valid, y0_ready, y1_ready;
    logic [31:0] d;
    logic        d_ready, y0_valid, y1_valid;
    logic [31:0] y0, y1;
    logic [2:0]  cnt0, cnt1;
`ifdef DEMUX1X2_BUF_STATS_EN
    logic [15:0] acc0, acc1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    demux1x2_buf #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .clrn(clrn), .flush(flush), .d(d), .s(s),
        .d_valid(d_valid), .d_ready(d_ready),
        .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
        .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
`ifdef DEMUX1X2_BUF_STATS_EN
        , .acc0(acc0), .acc1(acc1)
`endif
    );

    typedef struct {
        logic        clrn, flush, s, dv;
        logic [31:0] d;
        logic        r0, r1;
        logic        dr, v0;
        logic [31:0] y0;
        logic        v1;
        logic [31:0] y1;
        int          c0, c1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cl, logic fl, logic ss, logic dv, logic [31:0] dd,
                                logic r0, logic r1, logic dr, logic v0, logic [31:0] e0,
                                logic v1, logic [31:0] e1, int c0, int c1);
        vec_t v;
        v.clrn = cl; v.flush = fl; v.s = ss; v.dv = dv; v.d = dd;
        v.r0 = r0; v.r1 = r1; v.dr = dr; v.v0 = v0; v.y0 = e0;
        v.v1 = v1; v.y1 = e1; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cl, input logic fl, input logic ss, input logic dv,
                         input logic [31:0] dd, input logic r0, input logic r1);
        clrn = cl; flush = fl; s = ss; d_valid = dv; d = dd; y0_ready = r0; y1_ready = r1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 1, 32'h55, 0, 0);
        tick();

        // clrn flush s dv d r0 r1 | d_ready v0 y0 v1 y1 cnt0 cnt1
        vecs.push_back(mk(0,0,0,1,32'h55,0,0, 0,0,32'h0 ,0,32'h0 ,0,0)); // reset held
        vecs.push_back(mk(1,0,0,0,32'h0 ,0,0, 1,0,32'h0 ,0,32'h0 ,0,0)); // released
        vecs.push_back(mk(1,0,0,1,32'hA0,0,0, 1,0,32'h0 ,0,32'h0 ,0,0)); // route A0 -> ch0
        vecs.push_back(mk(1,0,1,1,32'hB1,0,0, 1,1,32'hA0,0,32'h0 ,1,0)); // route B1 -> ch1
        vecs.push_back(mk(1,0,0,1,32'hA2,0,0, 1,1,32'hA0,1,32'hB1,1,1)); // route A2 -> ch0
        vecs.push_back(mk(1,0,0,0,32'h0 ,1,0, 1,1,32'hA0,1,32'hB1,2,1)); // pop A0
        vecs.push_back(mk(1,0,0,0,32'h0 ,1,0, 1,1,32'hA2,1,32'hB1,1,1)); // pop A2
        vecs.push_back(mk(1,0,0,0,32'h0 ,1,0, 1,0,32'h0 ,1,32'hB1,0,1)); // ch0 empty
        vecs.push_back(mk(1,0,0,1,32'hC0,0,0, 1,0,32'h0 ,1,32'hB1,0,1)); // fill ch0
        vecs.push_back(mk(1,0,0,1,32'hC1,0,0, 1,1,32'hC0,1,32'hB1,1,1));
        vecs.push_back(mk(1,0,0,1,32'hC2,0,0, 1,1,32'hC0,1,32'hB1,2,1));
        vecs.push_back(mk(1,0,0,1,32'hC3,0,0, 1,1,32'hC0,1,32'hB1,3,1));
        vecs.push_back(mk(1,0,0,1,32'hC4,0,0, 0,1,32'hC0,1,32'hB1,4,1)); // full: 5th held
        vecs.push_back(mk(1,0,1,1,32'hC4,0,0, 1,1,32'hC0,1,32'hB1,4,1)); // redirect to ch1
        vecs.push_back(mk(1,0,0,1,32'hD0,1,0, 0,1,32'hC0,1,32'hB1,4,2)); // full + pop: refused
        vecs.push_back(mk(1,0,0,0,32'h0 ,0,0, 1,1,32'hC1,1,32'hB1,3,2));
        vecs.push_back(mk(1,0,1,1,32'hE0,0,1, 1,1,32'hC1,1,32'hB1,3,2)); // push+pop ch1
        vecs.push_back(mk(1,0,1,1,32'hE1,0,1, 1,1,32'hC1,1,32'hC4,3,2));
        vecs.push_back(mk(1,0,1,0,32'h0 ,0,0, 1,1,32'hC1,1,32'hE0,3,2)); // cnt1 held at 2
        vecs.push_back(mk(1,1,0,1,32'hF0,1,1, 0,1,32'hC1,1,32'hE0,3,2)); // flush
        vecs.push_back(mk(1,0,0,0,32'h0 ,0,0, 1,0,32'h0 ,0,32'h0 ,0,0)); // emptied
        vecs.push_back(mk(1,0,0,1,32'hF1,0,0, 1,0,32'h0 ,0,32'h0 ,0,0)); // F0 not stored
        vecs.push_back(mk(1,0,0,0,32'h0 ,1,0, 1,1,32'hF1,0,32'h0 ,1,0));
        vecs.push_back(mk(1,0,1,1,32'h60,0,0, 1,0,32'h0 ,0,32'h0 ,0,0)); // push before reset
        vecs.push_back(mk(0,1,1,1,32'h61,0,0, 0,0,32'h0 ,1,32'h60,0,1)); // reset mid-op
        vecs.push_back(mk(1,0,1,0,32'h0 ,0,0, 1,0,32'h0 ,0,32'h0 ,0,0)); // post-reset s=1
        vecs.push_back(mk(1,0,0,0,32'h0 ,0,0, 1,0,32'h0 ,0,32'h0 ,0,0)); // post-reset s=0

        foreach (vecs[i]) begin
            drive(vecs[i].clrn, vecs[i].flush, vecs[i].s, vecs[i].dv, vecs[i].d,
                  vecs[i].r0, vecs[i].r1);
            #2;
            $display("[TB] vec %0d: s=%0d dv=%0d d=%0h -> d_ready=%0d y0=%0h/%0d y1=%0h/%0d cnt=%0d,%0d",
                     i, s, d_valid, d, d_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1);
            check($sformatf("v%0d d_ready", i), 32'(d_ready),  32'(vecs[i].dr));
            check($sformatf("v%0d y0_valid", i), 32'(y0_valid), 32'(vecs[i].v0));
            check($sformatf("v%0d y0", i),       y0,            vecs[i].y0);
            check($sformatf("v%0d y1_valid", i), 32'(y1_valid), 32'(vecs[i].v1));
            check($sformatf("v%0d y1", i),       y1,            vecs[i].y1);
            check($sformatf("v%0d cnt0", i),     32'(cnt0),     32'(vecs[i].c0));
            check($sformatf("v%0d cnt1", i),     32'(cnt1),     32'(vecs[i].c1));
            tick();
        end

        // Stream 0..9 through channel 1 with a stuttering consumer; pointers wrap.
        begin
            logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            int sent = 0, got = 0, mcnt = 0, cyc = 0;
            while (got < 10 && cyc < 200) begin
                logic r, push, pop;
                r = pat[cyc % 5];
                drive(1, 0, 1, (sent < 10), 32'(sent), 0, r);
                #2;
                check("stream d_ready", 32'(d_ready), 32'(mcnt != 4));
                check("stream cnt1", 32'(cnt1), 32'(mcnt));
                push = (sent < 10) && (mcnt != 4);
                pop  = (mcnt != 0) && r;
                if (pop) begin
                    $display("[TB] stream cyc %0d: y1=%0h expect %0h", cyc, y1, got);
                    check("stream y1", y1, 32'(got));
                    got++;
                end
                if (push) sent++;
                mcnt = mcnt + (push ? 1 : 0) - (pop ? 1 : 0);
                tick();
                cyc++;
            end
            check("stream words delivered", 32'(got), 32'd10);
        end

`ifdef DEMUX1X2_BUF_STATS_EN
        begin
            drive(1, 1, 0, 0, 0, 1, 1);
            tick();
            for (int i = 0; i < 5; i++) begin
                drive(1, 0, (i >= 3), 1, 32'(i), 0, 0);
                tick();
            end
            drive(1, 0, 0, 0, 0, 0, 0);
            #2;
            $display("[TB] stats: acc0=%0d acc1=%0d", acc0, acc1);
            check("acc0 after 3", 32'(acc0), 32'd3);
            check("acc1 after 2", 32'(acc1), 32'd2);
            drive(1, 1, 0, 0, 0, 0, 0);
            tick();
            drive(1, 0, 0, 0, 0, 0, 0);
            #2;
            check("acc0 flushed", 32'(acc0), 32'd0);
            check("acc1 flushed", 32'(acc1), 32'd0);
            drive(1, 0, 0, 1, 32'h1, 1, 0);
            for (int i = 0; i < 65540; i++) tick();
            drive(1, 0, 0, 0, 0, 0, 0);
            #2;
            $display("[TB] stats saturate: acc0=%0h", acc0);
            check("acc0 saturated", 32'(acc0), 32'h0000FFFF);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
